// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter sharing one sin/cos CORDIC core among NREQ requesters.
// Optional WAIT timeout is compiled in with `define CORDIC_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int SZ      = 16,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_angle,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic signed [SZ:0]   rsp_cos,
  output logic signed [SZ:0]   rsp_sin,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 cordic_strobe,
  output logic [31:0]          cordic_angle,
  input  logic                 cordic_done,
  input  logic signed [SZ:0]   cordic_cos,
  input  logic signed [SZ:0]   cordic_sin
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cordic_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr;
  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic [31:0]           gnt_angle;
  logic                  accept;
  logic [31:0]           angle_p1;
  logic [IDW-1:0]        id_p1;
  logic [IDW-1:0]        rsp_id_q;
  logic signed [SZ:0]    rsp_cos_q, rsp_sin_q;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]         wait_cnt;
  logic                  timed_out;
  logic                  rsp_err_q;
`endif

  // Circular search from rr_ptr: lowest index >= rr_ptr wins, else lowest index overall.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_angle = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr))) begin
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        gnt_angle = req_angle[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cordic_done) begin
          state_d = RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          timed_out = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RESP) begin
        rr_ptr <= (id_p1 == IDW'(NREQ - 1)) ? '0 : id_p1 + 1'b1;
      end
    end
  end

  // Stage p1: accepted request, held for the life of the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      angle_p1 <= gnt_angle;
      id_p1    <= gnt_idx;
    end
  end

  // Result registers load on the WAIT->RESP edge so they stay stable until the next RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_id_q  <= '0;
      rsp_cos_q <= '0;
      rsp_sin_q <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
    end else if ((state_q == WAIT) && (state_d == RESP)) begin
      rsp_id_q  <= id_p1;
`ifdef CORDIC_ARB_TIMEOUT_EN
      rsp_err_q <= timed_out;
      rsp_cos_q <= timed_out ? '0 : cordic_cos;
      rsp_sin_q <= timed_out ? '0 : cordic_sin;
`else
      rsp_cos_q <= cordic_cos;
      rsp_sin_q <= cordic_sin;
`endif
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (state_q != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
  assign rsp_err = rst_n ? rsp_err_q : 1'b0;
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs are forced low while rst_n is asserted, before the reset edge lands.
  assign req_ready     = (rst_n && accept) ? (NREQ'(1) << gnt_idx) : '0;
  assign cordic_strobe = rst_n && (state_q == ISSUE);
  assign cordic_angle  = (rst_n && ((state_q == ISSUE) || (state_q == WAIT))) ? angle_p1 : '0;
  assign busy          = rst_n && (state_q != IDLE);
  assign rsp_valid     = rst_n && (state_q == RESP);
  assign rsp_id        = rst_n ? rsp_id_q  : '0;
  assign rsp_cos       = rst_n ? rsp_cos_q : '0;
  assign rsp_sin       = rst_n ? rsp_sin_q : '0;

endmodule
